sync_fifo_v2: RTL

Next-generation parametrised synchronous FIFO for single-clock datapaths.
- Generalised in depth and width.
- Selectable standard (registered-read) or first-word-fall-through (FWFT) mode.
- Occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.
- Used as the common buffering element between producer/consumer stages inside one clock domain.

---
 rtl/sync_fifo_pkg.sv | 25 ++
 rtl/fifo_ram_2p.sv | 32 +++
 rtl/sync_fifo_v2.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared helpers for sync_fifo_v2.
// - Width helpers for the pointer and occupancy fields.
// - Parameter legality check, evaluated when the design is elaborated.
package sync_fifo_pkg;

  // Storage address width.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Pointer / count width: the address bits plus one wrap bit.
  // This lets count reach DEPTH without ambiguity.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Returns 1 when DEPTH is a power of two >= 2 and both thresholds are in range.
  function automatic bit params_ok(input int depth, input int afull, input int aempty);
    bit pow2;
    pow2 = (depth >= 2) && ((depth & (depth - 1)) == 0);
    return pow2 && (afull >= 1) && (afull <= depth) &&
           (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Storage array for sync_fifo_v2.
// Ports:
//   clk          write clock
//   we, waddr,   synchronous write port
//   wdata
//   raddr, rdata asynchronous read port
// The read port is asynchronous so that FWFT mode can present the head
// word with no latency. Standard mode registers it in the top level.
// The array is deliberately left unreset, so its contents are undefined
// after reset.
module fifo_ram_2p #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_v2.sv
// Parametrised single-clock FIFO.
// It supports a standard (registered-read) mode and a
// first-word-fall-through (FWFT) mode.
// Ports:
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   cs                   chip select; gates wr_en and rd_en, but not flush
//   flush                synchronous clear of pointers, errors and data_out
//   wr_en, data_in       write request and write data
//   rd_en                read request; in FWFT mode this pops the head word
//   data_out             read data (registered in standard mode, head view in FWFT mode)
//   empty, full          status from count
//   almost_empty/full    threshold status from count
//   count                occupancy, 0..DEPTH
//   overflow, underflow  sticky error flags, cleared by flush or reset
module sync_fifo_v2
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 8,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cs,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_empty,
  output logic                    almost_full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int PTR_W  = ptr_w(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;

  localparam ptr_t FULL_CNT = ptr_t'(DEPTH);
  localparam ptr_t AF_CNT   = ptr_t'(AFULL_THRESH);
  localparam ptr_t AE_CNT   = ptr_t'(AEMPTY_THRESH);

  if (!params_ok(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
    $error("sync_fifo_v2: DEPTH must be a power of two >= 2 and thresholds in range");
  end

  ptr_t                  wr_ptr, rd_ptr;
  logic                  rd_acc, wr_acc;
  logic [DATA_WIDTH-1:0] rd_data;

  // All status is derived from the registered pointers. The wrap bit makes
  // the modular difference distinguish full from empty.
  assign count        = wr_ptr - rd_ptr;
  assign empty        = (count == '0);
  assign full         = (count == FULL_CNT);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // A write is accepted while full only if a read frees a slot in the same
  // cycle. A read of an empty FIFO is never accepted, so a simultaneous
  // write into an empty FIFO does not pass through to the reader.
  assign rd_acc = cs & rd_en & ~empty & ~flush;
  assign wr_acc = cs & wr_en & ~flush & (~full | rd_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (cs & wr_en & full & ~rd_acc) overflow  <= 1'b1;
      if (cs & rd_en & empty)          underflow <= 1'b1;
    end
  end

  fifo_ram_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  if (FWFT == 0) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      dout_q <= '0;
      else if (flush)  dout_q <= '0;
      else if (rd_acc) dout_q <= rd_data;
    end

    assign data_out = dout_q;
  end else begin : g_fwft
    // Head word is visible directly; the value is meaningless while empty.
    assign data_out = rd_data;
  end

endmodule
